// File: rtl/adc_block_average.sv
// Multi-channel block averager: sums 2^L consecutive samples per channel,
// emits the round-half-up mean once per window and pulses DONE.
module adc_block_average #(
  parameter int NUM_CH       = 2,
  parameter int ADC_WIDTH    = 12,
  parameter int LOG2_MAX_LEN = 10,
  parameter int SIGNED_IN    = 0
) (
  input  logic                                  ADC_CLK,
  input  logic                                  RST,
  input  logic                                  EN,
  input  logic [$clog2(LOG2_MAX_LEN+1)-1:0]     LOG2_LEN,
  input  logic [NUM_CH*ADC_WIDTH-1:0]           ADC_DATA_IN,
  output logic [NUM_CH*ADC_WIDTH-1:0]           AVE_OUT,
  output logic                                  DONE,
  output logic                                  BUSY,
  output logic [15:0]                           WIN_CNT
);

  localparam int LW = $clog2(LOG2_MAX_LEN+1);
  localparam int AW = ADC_WIDTH + LOG2_MAX_LEN;
  localparam int CW = (LOG2_MAX_LEN > 0) ? LOG2_MAX_LEN : 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              cnt;
  logic [LW-1:0]              l_win;
  logic [LW-1:0]              l_res;
  logic [LW-1:0]              l_req;
  logic [LW-1:0]              l_cur;
  logic                       last;
  logic                       pend;
  logic [AW-1:0]              acc [NUM_CH];
  logic [AW-1:0]              res [NUM_CH];
  logic [AW-1:0]              sum [NUM_CH];
  logic [NUM_CH*ADC_WIDTH-1:0] ave_nxt;

  // State register
  always_ff @(posedge ADC_CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: any EN=0 edge ends (or aborts) accumulation
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN)  state_nxt = ACCUM;
      ACCUM:   if (!EN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    BUSY = (state == ACCUM);
  end

  // Window length: clamp request; a zero counter marks sample 0, where L is (re)latched
  always_comb begin
    l_req = (LOG2_LEN > LW'(LOG2_MAX_LEN)) ? LW'(LOG2_MAX_LEN) : LOG2_LEN;
    l_cur = (cnt == '0) ? l_req : l_win;
    last  = (cnt == CW'(((CW+1)'(1) << l_cur) - (CW+1)'(1)));
  end

  // Per-channel extended sample plus running sum
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      logic [ADC_WIDTH-1:0] smp;
      logic                 sbit;
      smp    = ADC_DATA_IN[k*ADC_WIDTH +: ADC_WIDTH];
      sbit   = (SIGNED_IN != 0) && smp[ADC_WIDTH-1];
      sum[k] = acc[k] + {{LOG2_MAX_LEN{sbit}}, smp};
    end
  end

  // Rounded mean of the pending result; one guard bit keeps the rounding add exact
  always_comb begin
    ave_nxt = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      logic signed [AW:0] wide;
      logic signed [AW:0] rnd;
      logic signed [AW:0] rsum;
      wide = $signed({(SIGNED_IN != 0) && res[k][AW-1], res[k]});
      rnd  = (l_res == '0) ? '0 : $signed((AW+1)'(1) << (l_res - LW'(1)));
      rsum = wide + rnd;
      ave_nxt[k*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(rsum >>> l_res);
    end
  end

  // Accumulate, hand off completed sums, and run the output stage
  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      cnt     <= '0;
      l_win   <= '0;
      l_res   <= '0;
      pend    <= 1'b0;
      AVE_OUT <= '0;
      DONE    <= 1'b0;
      WIN_CNT <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        acc[k] <= '0;
        res[k] <= '0;
      end
    end else begin
      // Output stage is independent of EN so a finished window is never dropped
      DONE <= pend;
      if (pend) begin
        AVE_OUT <= ave_nxt;
        WIN_CNT <= WIN_CNT + 16'd1;
      end
      pend <= EN && last;
      if (EN) begin
        if (cnt == '0) l_win <= l_req;
        if (last) begin
          l_res <= l_cur;
          cnt   <= '0;
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            res[k] <= sum[k];
            acc[k] <= '0;
          end
        end else begin
          cnt <= cnt + CW'(1);
          for (int unsigned k = 0; k < NUM_CH; k++) acc[k] <= sum[k];
        end
      end else begin
        cnt <= '0;
        for (int unsigned k = 0; k < NUM_CH; k++) acc[k] <= '0;
      end
    end
  end

endmodule

// File: doc/adc_block_average.md
# adc_block_average

Parametrised multi-channel block averager for the ADC front end of the SPGD ADC→DAC loop. It accumulates a runtime-selectable, power-of-two number of consecutive ADC samples per channel, emits the rounded mean of each channel once per window, and pulses `DONE`. Windows run gap-free, so the loop logic downstream sees a steady stream of averaged samples. It is the generalised successor to the fixed 1024-sample, single-channel averager in the loop.

## Interface
- `NUM_CH`, default 2: number of ADC channels averaged in lockstep.
- `ADC_WIDTH`, default 12: bits per channel sample.
- `LOG2_MAX_LEN`, default 10: maximum window length is 2^LOG2_MAX_LEN samples.
- `SIGNED_IN`, default 0:
  - 0: samples are unsigned codes.
  - 1: samples are two's complement.
- `ADC_CLK`  in  1: sole clock; all logic on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `EN`  in  1: run enable; high means sample every clock.
- `LOG2_LEN`  in  $clog2(LOG2_MAX_LEN+1): window length exponent L; window = 2^L samples.
- `ADC_DATA_IN`  in  NUM_CH*ADC_WIDTH: channel k occupies bits [k*ADC_WIDTH +: ADC_WIDTH].
- `AVE_OUT`  out  NUM_CH*ADC_WIDTH: registered rounded means, same packing as the input.
- `DONE`  out  1: one-cycle strobe; `AVE_OUT` updated this cycle.
- `BUSY`  out  1: high while a window is in progress.
- `WIN_CNT`  out  16: completed-window counter; wraps 0xFFFF→0.

## Operation
- State machine has two states, IDLE and ACCUM.
  - IDLE → ACCUM on the first edge with `EN`=1. L is latched on this edge, and this edge's sample is sample 0.
  - ACCUM → IDLE on any edge with `EN`=0. The window is aborted: accumulators and sample counter are cleared, no `DONE`, and `AVE_OUT` holds its value.
- Latched L is clamped: if `LOG2_LEN` > LOG2_MAX_LEN, use LOG2_MAX_LEN. A `LOG2_LEN` change mid-window takes effect at the next window start only.
- Per channel, the accumulator is ADC_WIDTH+LOG2_MAX_LEN bits.
  - Sign-extended when SIGNED_IN=1, zero-extended otherwise.
  - Overflow is impossible by construction.
- Sample counter counts 0..2^L−1. On the edge that takes the last sample (count = 2^L−1):
  - sum = acc + sample goes to a result register, and a result-pending flag is set;
  - the accumulator and counter reset to 0;
  - the state stays ACCUM, and the next edge's sample is sample 0 of the next window, with L re-latched from `LOG2_LEN`.
- Next edge after result-pending is set:
  - `AVE_OUT` = (sum + 2^(L−1)) >>> L, i.e. round half up. For L=0 there is no rounding term; the output equals the sample.
  - The shift is arithmetic when signed. The result always fits in ADC_WIDTH bits, so there is no saturation.
  - `DONE` is 1 and `WIN_CNT` increments.
  - This output stage runs even if `EN` dropped on that edge; a completed window is never lost.
- `BUSY` is 1 in ACCUM, 0 in IDLE.
- Reset values: `AVE_OUT`=0, `DONE`=0, `BUSY`=0, `WIN_CNT`=0, state IDLE, accumulators and counter 0, result-pending 0.
- `RST` mid-window or with result pending: everything returns to reset values on that edge, and no `DONE` is generated.

## Timing
- Latency: the last-sample edge is T. `AVE_OUT` and `DONE` are valid after edge T+1, and `DONE` is high for exactly one cycle.
- Throughput: one averaged vector per 2^L clocks, with no dead cycles between windows.
  - With L=0, `DONE` is high every cycle, one cycle behind the input.
- `DONE` period equals 2^L clocks while `EN` stays high and L is constant.
- `EN` low for one cycle mid-window: that window is discarded, and a fresh window starts on the next `EN`=1 edge.
- `RST` has priority over `EN` on the same edge.

## Test plan
- Ramp, unsigned, NUM_CH=1, L=2, input 0,1,2,3,4,5,6,7 → `DONE` twice, 4 clocks apart; `AVE_OUT`=2 (6+2>>2), then 6 (22+2>>2); `WIN_CNT`=2.
- Full-scale and rounding, unsigned 12-bit, L=10, constant 0xFFF → `AVE_OUT`=0xFFF. Alternating 0/1, L=1 → 1 (round half up).
- Signed, SIGNED_IN=1, two channels, L=2:
  - ch0 = −1,−2,−1,−2 → −1 (−6+2 = −4, >>>2 = −1);
  - ch1 = −2048 constant → −2048.
- Abort: L=3, `EN` dropped after 5 samples, then held high with input 8 → no `DONE` for the aborted window; the first `DONE` comes 8 samples after `EN` re-rises with `AVE_OUT`=8.
- L change and clamp: `LOG2_LEN` set 2→4 mid-window → that window still ends at 4 samples, and the next at 16. `LOG2_LEN`=15 with LOG2_MAX_LEN=10 → 1024-sample windows.
- Reset: `RST` pulsed on the last-sample edge → no `DONE`, and all outputs read 0 the following cycle. `WIN_CNT` forced from 0xFFFF wraps to 0 on the next `DONE`.
